// File: rtl/otp_sequencer.sv
// otp_sequencer: sequences read and program cycles of an eFuse OTP macro.
//
// A read drives the word address with LOAD=1, waits T_SETUP cycles, pulses
// STROBE for T_RD_STB cycles (capturing efuse_q on the last one), then waits
// T_HOLD cycles. A program walks the set bits of req_wdata from bit 0
// upwards. Each bit gets its own SETUP / STROBE(T_PG_STB) / HOLD sequence,
// with VDDQ=1 and PGENB=0. Consecutive bits are separated by a single NEXT
// cycle.
//
// Optional feature: define OTP_BOOT_LOAD_EN to read words 0..BOOT_WORDS-1
// into boot_data after every reset. Requests are refused until this load
// finishes. Without the macro there is no BOOT state, boot_done is tied to 1
// and boot_data is tied to 0.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   req_valid/req_ready    request handshake (accepted when both are high)
//   req_pgm                1 = program, 0 = read
//   req_addr[6:0]          word address
//   req_wdata[7:0]         bits to blow
//   rsp_valid              one-cycle completion pulse
//   rsp_rdata[7:0]         read data, or the req_wdata echo for a program
//   busy                   high while the sequencer is not IDLE
//   efuse_csb/strobe/load/vddq/pgenb, efuse_a[9:0] = {bit, word}
//                          macro controls
//   efuse_q[7:0]           macro read data
//   boot_done, boot_data   boot shadow copy, word n at [8n+7:8n]
// All outputs come straight from registers.
module otp_sequencer #(
  parameter int T_SETUP    = 2,
  parameter int T_RD_STB   = 4,
  parameter int T_PG_STB   = 16,
  parameter int T_HOLD     = 2,
  parameter int BOOT_WORDS = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_pgm,
  input  logic [6:0]              req_addr,
  input  logic [7:0]              req_wdata,
  output logic                    rsp_valid,
  output logic [7:0]              rsp_rdata,
  output logic                    busy,
  output logic                    efuse_csb,
  output logic                    efuse_strobe,
  output logic                    efuse_load,
  output logic                    efuse_vddq,
  output logic                    efuse_pgenb,
  output logic [9:0]              efuse_a,
  input  logic [7:0]              efuse_q,
  output logic                    boot_done,
  output logic [8*BOOT_WORDS-1:0] boot_data
);

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, HOLD, NEXT
`ifdef OTP_BOOT_LOAD_EN
    , BOOT
`endif
  } state_t;

  typedef struct packed {
    logic csb;
    logic strobe;
    logic load;
    logic vddq;
    logic pgenb;
  } pins_t;

  localparam pins_t PINS_IDLE = '{csb: 1'b1, strobe: 1'b0, load: 1'b0, vddq: 1'b0, pgenb: 1'b1};
  localparam pins_t PINS_READ = '{csb: 1'b0, strobe: 1'b0, load: 1'b1, vddq: 1'b0, pgenb: 1'b1};
  localparam pins_t PINS_PROG = '{csb: 1'b0, strobe: 1'b0, load: 1'b0, vddq: 1'b1, pgenb: 1'b0};

  // Index of the lowest set bit (0 when none are set).
  function automatic logic [2:0] lowest_bit(input logic [7:0] v);
    lowest_bit = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_bit = 3'(i);
    end
  endfunction

  state_t     r_state, w_state;
  logic [7:0] r_cnt, w_cnt, w_len;
  logic       r_pgm, w_pgm;
  logic [6:0] r_addr, w_addr;
  logic [7:0] r_bits, w_bits;         // set bits still waiting for their strobe
  pins_t      r_pins, w_pins;
  logic [9:0] r_a, w_a;
  logic       r_rsp_valid, w_rsp_valid;
  logic [7:0] r_rdata, w_rdata;
  logic       r_ready, w_ready;
  logic       r_busy, w_busy;
  logic [2:0] w_first_bit, w_next_bit;
`ifdef OTP_BOOT_LOAD_EN
  logic                    r_boot_done, w_boot_done;
  logic [8*BOOT_WORDS-1:0] r_boot_data, w_boot_data;
  logic [6:0]              r_boot_idx, w_boot_idx;
`endif

  assign w_first_bit = lowest_bit(req_wdata);
  assign w_next_bit  = lowest_bit(r_bits);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_pgm       = r_pgm;
    w_addr      = r_addr;
    w_bits      = r_bits;
    w_pins      = r_pins;
    w_a         = r_a;
    w_rsp_valid = 1'b0;
    w_rdata     = r_rdata;
`ifdef OTP_BOOT_LOAD_EN
    w_boot_done = r_boot_done;
    w_boot_data = r_boot_data;
    w_boot_idx  = r_boot_idx;
`endif
    w_len = r_pgm ? 8'(T_PG_STB - 1) : 8'(T_RD_STB - 1);

    case (r_state)
      IDLE: begin
        if (req_valid && r_ready) begin
          w_addr = req_addr;
          w_pgm  = req_pgm;
          w_cnt  = '0;
          if (!req_pgm) begin
            w_state = SETUP;
            w_pins  = PINS_READ;
            w_a     = {3'b000, req_addr};
          end else begin
            w_rdata = req_wdata;
            if (req_wdata == 8'h00) begin
              // Nothing to blow: complete at once, pins stay idle.
              w_rsp_valid = 1'b1;
            end else begin
              w_state = SETUP;
              w_pins  = PINS_PROG;
              w_a     = {w_first_bit, req_addr};
              w_bits  = req_wdata & ~(8'h01 << w_first_bit);
            end
          end
        end
      end
      SETUP: begin
        if (r_cnt == 8'(T_SETUP - 1)) begin
          w_cnt         = '0;
          w_state       = STROBE;
          w_pins.strobe = 1'b1;
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end
      STROBE: begin
        if (r_cnt == w_len) begin
          w_cnt         = '0;
          w_state       = HOLD;
          w_pins.strobe = 1'b0;
          // efuse_q is still valid on the edge that ends the last strobe cycle.
          if (!r_pgm) begin
`ifdef OTP_BOOT_LOAD_EN
            if (!r_boot_done) begin
              for (int n = 0; n < BOOT_WORDS; n++) begin
                if (r_boot_idx == 7'(n)) w_boot_data[8*n +: 8] = efuse_q;
              end
            end else
`endif
            w_rdata = efuse_q;
          end
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end
      HOLD: begin
        if (r_cnt == 8'(T_HOLD - 1)) begin
          w_cnt = '0;
`ifdef OTP_BOOT_LOAD_EN
          if (!r_boot_done) begin
            if (r_boot_idx == 7'(BOOT_WORDS - 1)) begin
              w_state     = IDLE;
              w_pins      = PINS_IDLE;
              w_boot_done = 1'b1;
            end else begin
              // Boot words run back to back; A moves while STROBE is low.
              w_boot_idx = r_boot_idx + 7'd1;
              w_a        = {3'b000, r_boot_idx + 7'd1};
              w_state    = SETUP;
            end
          end else
`endif
          if (r_pgm && (r_bits != 8'h00)) begin
            w_state = NEXT;
          end else begin
            w_state     = IDLE;
            w_pins      = PINS_IDLE;
            w_rsp_valid = 1'b1;
          end
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end
      NEXT: begin
        // CSB and VDDQ stay asserted; only the bit field of A moves.
        w_a     = {w_next_bit, r_addr};
        w_bits  = r_bits & ~(8'h01 << w_next_bit);
        w_state = SETUP;
      end
`ifdef OTP_BOOT_LOAD_EN
      BOOT: begin
        w_state    = SETUP;
        w_pins     = PINS_READ;
        w_a        = '0;
        w_boot_idx = '0;
        w_pgm      = 1'b0;
        w_cnt      = '0;
      end
`endif
      default: begin
        w_state = IDLE;
        w_pins  = PINS_IDLE;
      end
    endcase

    // Ready stays low in the completion cycle, so a held request is taken
    // one cycle after rsp_valid.
    w_ready = (w_state == IDLE) && !w_rsp_valid;
`ifdef OTP_BOOT_LOAD_EN
    w_ready = w_ready && w_boot_done;
`endif
    w_busy = (w_state != IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its pre-edge value.
    if (!rst_n) begin
`ifdef OTP_BOOT_LOAD_EN
      r_state     <= BOOT;
      r_ready     <= 1'b0;
      r_busy      <= 1'b1;
      r_boot_done <= 1'b0;
      // NOTE: boot_data is a flop bank (not RAM) and must read 0 after
      // reset, so it is reset like any other register.
      r_boot_data <= '0;
      r_boot_idx  <= '0;
`else
      r_state     <= IDLE;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
`endif
      r_cnt       <= '0;
      r_pgm       <= 1'b0;
      r_addr      <= '0;
      r_bits      <= '0;
      r_pins      <= PINS_IDLE;
      r_a         <= '0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_state     <= w_state;
      r_ready     <= w_ready;
      r_busy      <= w_busy;
`ifdef OTP_BOOT_LOAD_EN
      r_boot_done <= w_boot_done;
      r_boot_data <= w_boot_data;
      r_boot_idx  <= w_boot_idx;
`endif
      r_cnt       <= w_cnt;
      r_pgm       <= w_pgm;
      r_addr      <= w_addr;
      r_bits      <= w_bits;
      r_pins      <= w_pins;
      r_a         <= w_a;
      r_rsp_valid <= w_rsp_valid;
      r_rdata     <= w_rdata;
    end
  end

  assign req_ready    = r_ready;
  assign busy         = r_busy;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_rdata    = r_rdata;
  assign efuse_csb    = r_pins.csb;
  assign efuse_strobe = r_pins.strobe;
  assign efuse_load   = r_pins.load;
  assign efuse_vddq   = r_pins.vddq;
  assign efuse_pgenb  = r_pins.pgenb;
  assign efuse_a      = r_a;
`ifdef OTP_BOOT_LOAD_EN
  assign boot_done    = r_boot_done;
  assign boot_data    = r_boot_data;
`else
  assign boot_done    = 1'b1;
  assign boot_data    = '0;
`endif

endmodule

// File: tb/tb_otp_sequencer.sv
// tb_otp_sequencer: self-checking bench for otp_sequencer with a behavioural
// eFuse macro. A read presents the word while CSB=0, LOAD=1 and STROBE=1.
// A program strobe blows bit A[9:7] of word A[6:0] when the strobe rises.
// Expected responses are queued when a request is accepted. They are compared
// when rsp_valid pulses.
module tb_otp_sequencer;
  localparam int T_SETUP    = 2;
  localparam int T_RD_STB   = 4;
  localparam int T_PG_STB   = 16;
  localparam int T_HOLD     = 2;
  localparam int BOOT_WORDS = 10;
  localparam int RD_LAT     = 1 + T_SETUP + T_RD_STB + T_HOLD;
`ifdef OTP_BOOT_LOAD_EN
  localparam bit BOOT_EN = 1'b1;
`else
  localparam bit BOOT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic req_pgm = 1'b0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic req_ready, rsp_valid, busy, boot_done;
  logic [7:0] rsp_rdata, efuse_q;
  logic efuse_csb, efuse_strobe, efuse_load, efuse_vddq, efuse_pgenb;
  logic [9:0] efuse_a;
  logic [8*BOOT_WORDS-1:0] boot_data;

  logic [7:0] fuse [128];
  assign efuse_q = (!efuse_csb && efuse_load && efuse_strobe) ? fuse[efuse_a[6:0]] : 8'h00;

  otp_sequencer #(
    .T_SETUP(T_SETUP), .T_RD_STB(T_RD_STB), .T_PG_STB(T_PG_STB),
    .T_HOLD(T_HOLD), .BOOT_WORDS(BOOT_WORDS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_pgm(req_pgm),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .efuse_csb(efuse_csb), .efuse_strobe(efuse_strobe), .efuse_load(efuse_load),
    .efuse_vddq(efuse_vddq), .efuse_pgenb(efuse_pgenb), .efuse_a(efuse_a),
    .efuse_q(efuse_q), .boot_done(boot_done), .boot_data(boot_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct { logic [7:0] rdata; int at; } rsp_t;
  typedef struct { logic [9:0] a; int width; } pulse_t;
  rsp_t   sb[$];
  pulse_t pulses[$];
  pulse_t cur = '{10'h000, 0};
  int viol = 0;
  int csb_low = 0;
  logic prev_strobe = 1'b0;
  logic [13:0] prev_ctl = '0;

  // Monitor: protocol rules, strobe pulse recording, fuse blowing, scoreboard.
  always @(negedge clk) begin
    logic [13:0] ctl;
    rsp_t e;
    ctl = {efuse_csb, efuse_load, efuse_vddq, efuse_pgenb, efuse_a};
    if (efuse_strobe && (ctl != prev_ctl)) viol++;
    if (efuse_vddq && efuse_load) viol++;
    if (busy && req_ready) viol++;
    if (!efuse_csb) csb_low++;
    if (efuse_strobe && !prev_strobe) begin
      cur.a = efuse_a;
      cur.width = 1;
      if (!efuse_pgenb && efuse_vddq && !efuse_csb) fuse[efuse_a[6:0]][efuse_a[9:7]] = 1'b1;
    end else if (efuse_strobe) begin
      cur.width++;
    end else if (prev_strobe) begin
      pulses.push_back(cur);
    end
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_cycle", cyc, e.at);
      end
    end
    prev_strobe = efuse_strobe;
    prev_ctl = ctl;
  end

  task automatic send(input logic pgm, input logic [6:0] addr, input logic [7:0] wdata,
                      input logic [7:0] exp, input int lat, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_pgm = pgm; req_addr = addr; req_wdata = wdata;
    while (!req_ready && n < 3000) begin @(negedge clk); n++; end
    if (!req_ready) check("accept_timeout", 32'd1, 32'd0);
    else if (push) sb.push_back('{exp, cyc + lat});
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    check({name, "_drain"}, sb.size(), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic pgm; logic [6:0] addr; logic [7:0] wdata; logic [7:0] exp;
    int lat; int npulse; logic [9:0] a0; logic [9:0] a1; bit csb_idle;
  } vec_t;
  vec_t vecs[7];

  initial begin
    int n, k1, k2, c0;
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k1, k2, c0;
    for (int i = 0; i < 128; i++) fuse[i] = 8'h00;
    fuse[0] = 8'h10; fuse[1] = 8'hFF; fuse[3] = 8'hFF;

    //        pgm   addr     wdata  exp    lat npulse a0       a1       csb_idle
    vecs[0] = '{1'b0, 7'd3,   8'h00, 8'hFF, 9,  1,     10'h003, 10'h000, 1'b0};
    vecs[1] = '{1'b0, 7'd0,   8'h00, 8'h10, 9,  1,     10'h000, 10'h000, 1'b0};
    vecs[2] = '{1'b1, 7'd2,   8'h81, 8'h81, 42, 2,     10'h002, 10'h382, 1'b0};
    vecs[3] = '{1'b0, 7'd2,   8'h00, 8'h81, 9,  1,     10'h002, 10'h000, 1'b0};
    vecs[4] = '{1'b1, 7'd2,   8'h00, 8'h00, 1,  0,     10'h000, 10'h000, 1'b1};
    vecs[5] = '{1'b1, 7'd127, 8'h24, 8'h24, 42, 2,     10'h17F, 10'h2FF, 1'b0};
    vecs[6] = '{1'b0, 7'd127, 8'h00, 8'h24, 9,  1,     10'h07F, 10'h000, 1'b0};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_csb", efuse_csb, 1);
    check("rst_strobe", efuse_strobe, 0);
    check("rst_load", efuse_load, 0);
    check("rst_vddq", efuse_vddq, 0);
    check("rst_pgenb", efuse_pgenb, 1);
    check("rst_a", efuse_a, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_boot_data", (boot_data == '0) ? 32'd1 : 32'd0, 32'd1);
    check("rst_boot_done", boot_done, !BOOT_EN);
    check("rst_ready", req_ready, !BOOT_EN);
    check("rst_busy", busy, BOOT_EN);
    rst_n = 1'b1;
    c0 = cyc;
`ifdef OTP_BOOT_LOAD_EN
    n = 0;
    while (!boot_done && n < 3000) begin @(negedge clk); n++; end
    check("boot_done_cycle", cyc, c0 + 1 + BOOT_WORDS * (T_SETUP + T_RD_STB + T_HOLD));
    check("boot_word0", boot_data[7:0], 8'h10);
    check("boot_word1", boot_data[15:8], 8'hFF);
    check("boot_ready", req_ready, 1);
`else
    @(negedge clk);
    check("ready_after_reset", req_ready, 1);
    check("busy_after_reset", busy, 0);
`endif

    // Table-driven requests.
    for (int i = 0; i < 7; i++) begin
      pulses.delete();
      csb_low = 0;
      send(vecs[i].pgm, vecs[i].addr, vecs[i].wdata, vecs[i].exp, vecs[i].lat, 1'b1);
      wait_drain($sformatf("v%0d", i));
      check($sformatf("v%0d_npulse", i), pulses.size(), vecs[i].npulse);
      for (int j = 0; j < pulses.size() && j < 2; j++) begin
        check($sformatf("v%0d_p%0d_a", i, j), pulses[j].a, (j == 0) ? vecs[i].a0 : vecs[i].a1);
        check($sformatf("v%0d_p%0d_w", i, j), pulses[j].width, vecs[i].pgm ? T_PG_STB : T_RD_STB);
      end
      if (vecs[i].csb_idle) check($sformatf("v%0d_csb_idle", i), csb_low, 0);
    end

    // req_valid held across two reads: the second is ignored while busy and
    // is taken one cycle after the first completes.
    @(negedge clk);
    req_valid = 1'b1; req_pgm = 1'b0; req_addr = 7'd1; req_wdata = 8'h00;
    n = 0;
    while (!req_ready && n < 3000) begin @(negedge clk); n++; end
    k1 = cyc;
    sb.push_back('{8'hFF, k1 + RD_LAT});
    @(negedge clk);
    req_addr = 7'd0;
    n = 0;
    while (!req_ready && n < 3000) begin @(negedge clk); n++; end
    k2 = cyc;
    sb.push_back('{8'h10, k2 + RD_LAT});
    check("b2b_accept_cycle", k2, k1 + RD_LAT + 1);
    @(negedge clk);
    req_valid = 1'b0;
    wait_drain("b2b");

    // Reset in the middle of the first program strobe of word 10.
    send(1'b1, 7'd10, 8'h03, 8'h00, 0, 1'b0);
    n = 0;
    while (!efuse_strobe && n < 100) begin @(negedge clk); n++; end
    check("rst_pgm_strobe_seen", efuse_strobe, 1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_pgm_strobe", efuse_strobe, 0);
    check("rst_pgm_vddq", efuse_vddq, 0);
    check("rst_pgm_csb", efuse_csb, 1);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    pulses.delete();
    send(1'b0, 7'd10, 8'h00, 8'h01, RD_LAT, 1'b1);
    wait_drain("rst_pgm_read");
    check("rst_pgm_read_npulse", pulses.size(), 1);

    check("protocol_violations", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
